// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared types and helpers for the 4-way round-robin mux controller.
// Holds the state encoding, requester count, select width and the next-owner scan.
package mux4_rr_arbiter_pkg;

    localparam int NUM_REQ = 4;
    localparam int SEL_W   = 2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    // Returns {found, index} of the first set request scanning start, start+1, ... mod 4.
    function automatic logic [SEL_W:0] next_owner(input logic [NUM_REQ-1:0] req,
                                                  input logic [SEL_W-1:0]   start);
        logic [SEL_W:0]   result;
        logic [SEL_W-1:0] idx;
        result = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = start + SEL_W'(k);
            if (req[idx]) begin
                result = {1'b1, idx};
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/mux4_rr_arbiter_data.sv
// DATA_W-wide 4:1 data mux driven by the arbiter's registered select.
// Purely combinational; channel i lives at data_in[i*DATA_W +: DATA_W].
module mux4_data
    import mux4_rr_arbiter_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [NUM_REQ*DATA_W-1:0] data_in,
    input  logic [SEL_W-1:0]          sel,
    output logic [DATA_W-1:0]         out_data
);

    always_comb begin
        out_data = data_in[0 +: DATA_W];
        case (sel)
            2'd0:    out_data = data_in[0*DATA_W +: DATA_W];
            2'd1:    out_data = data_in[1*DATA_W +: DATA_W];
            2'd2:    out_data = data_in[2*DATA_W +: DATA_W];
            2'd3:    out_data = data_in[3*DATA_W +: DATA_W];
            default: out_data = data_in[0 +: DATA_W];
        endcase
    end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin controller sharing one 4:1 data mux among four requesters.
// Registers grant/sel, caps beats per owner at MAX_BURST and handshakes with one sink.
module mux4_rr_arbiter
    import mux4_rr_arbiter_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] data_in,
    output logic [NUM_REQ-1:0]        grant,
    output logic [SEL_W-1:0]          sel,
    output logic                      out_valid,
    output logic [DATA_W-1:0]         out_data,
    input  logic                      out_ready
);

    localparam int               CNT_W     = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);

    state_t             state;
    state_t             state_n;
    logic [SEL_W-1:0]   ptr;
    logic [SEL_W-1:0]   ptr_n;
    logic [SEL_W-1:0]   sel_n;
    logic [NUM_REQ-1:0] grant_n;
    logic [CNT_W-1:0]   beat_cnt;
    logic [CNT_W-1:0]   cnt_n;
    logic               xfer;
    logic               release_owner;
    logic [SEL_W-1:0]   scan_start;
    logic [SEL_W:0]     pick;

    // Handshake: a beat moves only on a cycle where out_valid & out_ready are both high.
    // out_valid follows the owner's req combinationally, so an owner that drops req
    // while stalled withdraws its beat in that same cycle and nothing is transferred.
    always_comb begin
        out_valid     = (state == ST_BUSY) & req[sel];
        xfer          = out_valid & out_ready;
        release_owner = (state == ST_BUSY) &
                        (~req[sel] | (xfer & (beat_cnt == LAST_BEAT)));
    end

    always_comb begin
        state_n    = state;
        ptr_n      = ptr;
        sel_n      = sel;
        grant_n    = grant;
        cnt_n      = beat_cnt;
        // On release the scan starts just past the outgoing owner, so a lone
        // requester at its cap wins again without a bubble.
        scan_start = (state == ST_BUSY) ? sel + SEL_W'(1) : ptr;
        pick       = next_owner(req, scan_start);
        case (state)
            ST_IDLE: begin
                if (pick[SEL_W]) begin
                    state_n = ST_BUSY;
                    sel_n   = pick[SEL_W-1:0];
                    grant_n = NUM_REQ'(1) << pick[SEL_W-1:0];
                    cnt_n   = '0;
                end
            end
            ST_BUSY: begin
                if (release_owner) begin
                    ptr_n = scan_start;
                    cnt_n = '0;
                    if (pick[SEL_W]) begin
                        sel_n   = pick[SEL_W-1:0];
                        grant_n = NUM_REQ'(1) << pick[SEL_W-1:0];
                    end else begin
                        state_n = ST_IDLE;
                        grant_n = '0;
                    end
                end else if (xfer) begin
                    cnt_n = beat_cnt + CNT_W'(1);
                end
            end
            default: begin
                state_n = ST_IDLE;
                grant_n = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            ptr      <= '0;
            beat_cnt <= '0;
            grant    <= '0;
            sel      <= '0;
        end else begin
            state    <= state_n;
            ptr      <= ptr_n;
            beat_cnt <= cnt_n;
            grant    <= grant_n;
            sel      <= sel_n;
        end
    end

    mux4_data #(
        .DATA_W(DATA_W)
    ) u_data (
        .data_in (data_in),
        .sel     (sel),
        .out_data(out_data)
    );

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed bench for mux4_rr_arbiter: per-cycle vector table plus hand sequences
// for asynchronous reset mid-burst and the MAX_BURST=1 rotation case.
module tb_mux4_rr_arbiter;

    typedef struct packed {
        logic       rst_n;
        logic [3:0] req;
        logic       rdy;
        logic [3:0] grant;
        logic [1:0] sel;
        logic       valid;
        logic [7:0] data;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req;
    logic [31:0] data_in;
    logic        out_ready;
    logic [3:0]  grant;
    logic [1:0]  sel;
    logic        out_valid;
    logic [7:0]  out_data;
    logic [3:0]  grant1;
    logic [1:0]  sel1;
    logic        out_valid1;
    logic [7:0]  out_data1;

    int   n_cmp = 0;
    int   n_err = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    mux4_rr_arbiter #(.DATA_W(8), .MAX_BURST(4)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .data_in(data_in),
        .grant(grant), .sel(sel), .out_valid(out_valid),
        .out_data(out_data), .out_ready(out_ready)
    );

    mux4_rr_arbiter #(.DATA_W(8), .MAX_BURST(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .req(req), .data_in(data_in),
        .grant(grant1), .sel(sel1), .out_valid(out_valid1),
        .out_data(out_data1), .out_ready(out_ready)
    );

    task automatic chk(input string nm, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s[%0d]: got %0h expected %0h", nm, idx, act, exp);
        end
    endtask

    task automatic add(input logic r_n, input logic [3:0] r, input logic rdy,
                       input logic [3:0] g, input logic [1:0] s, input logic v);
        vec_t e;
        e.rst_n = r_n;
        e.req   = r;
        e.rdy   = rdy;
        e.grant = g;
        e.sel   = s;
        e.valid = v;
        e.data  = 8'hA0 + {6'd0, s};
        vecs.push_back(e);
    endtask

    initial begin
        rst_n     = 1'b0;
        req       = 4'h0;
        out_ready = 1'b0;
        data_in   = {8'hA3, 8'hA2, 8'hA1, 8'hA0};

        // Fairness: all request, sink always ready, owners rotate every 4 beats.
        add(0, 4'hF, 1, 4'h0, 0, 0);
        add(1, 4'hF, 1, 4'h0, 0, 0);
        for (int o = 0; o < 4; o++)
            for (int b = 0; b < 4; b++)
                add(1, 4'hF, 1, 4'(1 << o), 2'(o), 1);
        add(1, 4'hF, 1, 4'h1, 0, 1);

        // Back-pressure on owner 2, then exactly 4 beats before rotating to 3.
        add(0, 4'hC, 0, 4'h0, 0, 0);
        add(1, 4'hC, 0, 4'h0, 0, 0);
        for (int i = 0; i < 5; i++) add(1, 4'hC, 0, 4'h4, 2, 1);
        for (int i = 0; i < 4; i++) add(1, 4'hC, 1, 4'h4, 2, 1);
        add(1, 4'hC, 1, 4'h8, 3, 1);

        // Early release: owner 1 drops after 2 beats, owner 3 takes over with no gap.
        add(0, 4'hA, 1, 4'h0, 0, 0);
        add(1, 4'hA, 1, 4'h0, 0, 0);
        add(1, 4'hA, 1, 4'h2, 1, 1);
        add(1, 4'hA, 1, 4'h2, 1, 1);
        add(1, 4'h8, 1, 4'h2, 1, 0);
        add(1, 4'h8, 1, 4'h8, 3, 1);

        // Lone requester streams without bubbles, then drops req while stalled.
        add(0, 4'h1, 1, 4'h0, 0, 0);
        add(1, 4'h1, 1, 4'h0, 0, 0);
        for (int i = 0; i < 10; i++) add(1, 4'h1, 1, 4'h1, 0, 1);
        add(1, 4'h1, 0, 4'h1, 0, 1);
        add(1, 4'h1, 0, 4'h1, 0, 1);
        add(1, 4'h0, 0, 4'h1, 0, 0);
        add(1, 4'h0, 0, 4'h0, 0, 0);

        foreach (vecs[i]) begin
            @(negedge clk);
            rst_n     = vecs[i].rst_n;
            req       = vecs[i].req;
            out_ready = vecs[i].rdy;
            #1;
            chk("grant", i, 32'(grant), 32'(vecs[i].grant));
            chk("sel", i, 32'(sel), 32'(vecs[i].sel));
            chk("out_valid", i, 32'(out_valid), 32'(vecs[i].valid));
            chk("out_data", i, 32'(out_data), 32'(vecs[i].data));
        end

        // Asynchronous reset between edges while owner 1 is mid-burst.
        @(negedge clk);
        rst_n = 1'b0; req = 4'hF; out_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        #1;
        chk("pre_rst_grant", 0, 32'(grant), 32'h2);
        chk("pre_rst_valid", 0, 32'(out_valid), 32'h1);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_grant", 0, 32'(grant), 32'h0);
        chk("async_valid", 0, 32'(out_valid), 32'h0);
        chk("async_sel", 0, 32'(sel), 32'h0);
        chk("async_data", 0, 32'(out_data), 32'hA0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_rst_idle", 0, 32'(grant), 32'h0);
        @(negedge clk);
        #1;
        chk("post_rst_grant", 0, 32'(grant), 32'h1);
        chk("post_rst_sel", 0, 32'(sel), 32'h0);

        // MAX_BURST=1 instance: rotates after every beat, holds while stalled.
        @(negedge clk);
        rst_n = 1'b0; req = 4'hF; out_ready = 1'b1;
        #1;
        chk("mb1_rst_grant", 0, 32'(grant1), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("mb1_idle_valid", 0, 32'(out_valid1), 32'h0);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            #1;
            chk("mb1_sel", k, 32'(sel1), 32'(k % 4));
            chk("mb1_grant", k, 32'(grant1), 32'(1 << (k % 4)));
            chk("mb1_valid", k, 32'(out_valid1), 32'h1);
        end
        @(negedge clk);
        out_ready = 1'b0;
        #1;
        chk("mb1_stall_sel", 0, 32'(sel1), 32'h2);
        @(negedge clk);
        #1;
        chk("mb1_stall_sel", 1, 32'(sel1), 32'h2);
        chk("mb1_stall_data", 1, 32'(out_data1), 32'hA2);
        out_ready = 1'b1;
        @(negedge clk);
        #1;
        chk("mb1_resume_sel", 0, 32'(sel1), 32'h3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
